// File: rtl/mem_arbiter_rrb.sv
// ---------------------------------------------------------------------------
// mem_arbiter_rrb
//
// Round-robin memory arbiter with a two-level priority class, a burst limit
// and a per-port lock that exempts the holder from that limit.
//
// The grant comes out of a registered FSM:
//   S_IDLE  choose a winner from req/prio, searching from last+1
//   S_BUSY  hold the grant until the holder drops req, or until the burst
//           limit is reached while another port is waiting
//   S_ITER  dead cycle after a grant ends; last is updated here
// Every handover therefore has two dead cycles (S_ITER, then S_IDLE).
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   req        [PORT]  per-port request, level-sensitive
//   prio       [PORT]  per-port high-priority qualifier, sampled with req
//   lock       [PORT]  per-port lock, holder ignores the burst limit
//   grant      [PORT]  registered one-hot grant or all-zero
//   grant_vld          registered OR of grant
//   grant_id   [IDW]   registered index of the granted port, holds when idle
//   preempt            registered one-cycle pulse when the burst limit
//                      revokes a grant
// ---------------------------------------------------------------------------
module mem_arbiter_rrb #(
    parameter int unsigned PORT      = 8,
    parameter int unsigned BURST_MAX = 16,
    parameter int unsigned IDW       = $clog2(PORT),
    parameter int unsigned CNTW      = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PORT-1:0] req,
    input  logic [PORT-1:0] prio,
    input  logic [PORT-1:0] lock,
    output logic [PORT-1:0] grant,
    output logic            grant_vld,
    output logic [IDW-1:0]  grant_id,
    output logic            preempt
);

    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_BUSY = 3'b010,
        S_ITER = 3'b100
    } state_e;

    localparam logic [CNTW-1:0] BURST_LIM = CNTW'(BURST_MAX);
    localparam logic [IDW-1:0]  LAST_RST  = IDW'(PORT - 1);

    state_e            state_q, state_d;
    logic [PORT-1:0]   grant_q, grant_d;
    logic              vld_q, vld_d;
    logic [IDW-1:0]    id_q, id_d;
    logic              preempt_q, preempt_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [IDW-1:0]    last_q, last_d;

    // Winner search
    logic [31:0]       idx;
    logic [IDW-1:0]    cur;
    logic              hit_hi, hit_any;
    logic [IDW-1:0]    win_hi, win_any;
    logic [IDW-1:0]    winner;

    // Status of the current holder
    logic              hold_req;
    logic              hold_lock;
    logic              others_req;

    // Scan ports in order last+1, last+2, ... wrapping; remember the first
    // requester overall and the first requester with prio set.
    always_comb begin
        idx     = '0;
        cur     = '0;
        hit_hi  = 1'b0;
        hit_any = 1'b0;
        win_hi  = '0;
        win_any = '0;
        for (int unsigned i = 1; i <= PORT; i++) begin
            idx = 32'(last_q) + 32'(i);
            if (idx >= 32'(PORT)) begin
                idx = idx - 32'(PORT);
            end
            cur = idx[IDW-1:0];
            if (req[cur]) begin
                if (!hit_any) begin
                    hit_any = 1'b1;
                    win_any = cur;
                end
                if (prio[cur] && !hit_hi) begin
                    hit_hi = 1'b1;
                    win_hi = cur;
                end
            end
        end
        winner = hit_hi ? win_hi : win_any;
    end

    assign hold_req   = |(req & grant_q);
    assign hold_lock  = |(lock & grant_q);
    assign others_req = |(req & ~grant_q);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        vld_d     = vld_q;
        id_d      = id_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        preempt_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                grant_d = '0;
                vld_d   = 1'b0;
                if (|req) begin
                    grant_d[winner] = 1'b1;
                    vld_d           = 1'b1;
                    id_d            = winner;
                    cnt_d           = CNTW'(1);
                    state_d         = S_BUSY;
                end
            end

            S_BUSY: begin
                if (!hold_req) begin
                    grant_d = '0;
                    vld_d   = 1'b0;
                    last_d  = id_q;
                    cnt_d   = '0;
                    state_d = S_ITER;
                end else if ((cnt_q == BURST_LIM) && !hold_lock && others_req) begin
                    // Burst limit reached with someone waiting: revoke.
                    grant_d   = '0;
                    vld_d     = 1'b0;
                    last_d    = id_q;
                    cnt_d     = '0;
                    preempt_d = 1'b1;
                    state_d   = S_ITER;
                end else if (cnt_q < BURST_LIM) begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end

            S_ITER: begin
                grant_d = '0;
                vld_d   = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                // Corrupted state register: drop everything and rearbitrate.
                grant_d = '0;
                vld_d   = 1'b0;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            vld_q     <= 1'b0;
            id_q      <= '0;
            preempt_q <= 1'b0;
            cnt_q     <= '0;
            last_q    <= LAST_RST;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            vld_q     <= vld_d;
            id_q      <= id_d;
            preempt_q <= preempt_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
        end
    end

    assign grant     = grant_q;
    assign grant_vld = vld_q;
    assign grant_id  = id_q;
    assign preempt   = preempt_q;

endmodule

// File: tb/tb_mem_arbiter_rrb.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter_rrb
//
// Self-checking bench for mem_arbiter_rrb (PORT=8, BURST_MAX=4). A
// transaction-level model tracks the current holder, its grant length, the
// dead cycles after a handover and the last-winner pointer, and predicts
// every output each cycle. Directed scenarios plus randomized traffic.
// ---------------------------------------------------------------------------
module tb_mem_arbiter_rrb;

    localparam int PORT  = 8;
    localparam int BURST = 4;
    localparam int IDW   = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [PORT-1:0] req, prio, lock;
    logic [PORT-1:0] grant;
    logic            grant_vld;
    logic [IDW-1:0]  grant_id;
    logic            preempt;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_holder;   // granted port, -1 when none
    int m_held;     // cycles the holder has been granted, saturating
    int m_gap;      // 1 while in the dead cycle right after a release
    int m_last;
    int m_id;
    bit m_pre;

    // Scenario bookkeeping
    int          n_seen, gap_cnt, pre_cnt, cnt_a, cnt_b;
    logic        prev_vld;
    logic [7:0]  rr, pp, ll;

    always #5 clk = ~clk;

    mem_arbiter_rrb #(
        .PORT      (PORT),
        .BURST_MAX (BURST),
        .IDW       (IDW),
        .CNTW      (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .prio      (prio),
        .lock      (lock),
        .grant     (grant),
        .grant_vld (grant_vld),
        .grant_id  (grant_id),
        .preempt   (preempt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // First prio requester in search order, else first requester.
    function automatic int pick(input logic [7:0] r, input logic [7:0] p, input int last);
        int any = -1;
        int hi  = -1;
        int k2;
        for (int k = 1; k <= PORT; k++) begin
            k2 = (last + k) % PORT;
            if (r[k2]) begin
                if (any < 0) any = k2;
                if (p[k2] && hi < 0) hi = k2;
            end
        end
        return (hi >= 0) ? hi : any;
    endfunction

    task automatic model_reset();
        m_holder = -1;
        m_held   = 0;
        m_gap    = 0;
        m_last   = PORT - 1;
        m_id     = 0;
        m_pre    = 1'b0;
    endtask

    task automatic model_step(input logic [7:0] r, input logic [7:0] p, input logic [7:0] l);
        logic [7:0] others;
        m_pre = 1'b0;
        if (m_holder >= 0) begin
            others = r;
            others[m_holder] = 1'b0;
            if (!r[m_holder]) begin
                m_last = m_holder; m_holder = -1; m_gap = 1;
            end else if (m_held == BURST && !l[m_holder] && others != 0) begin
                m_last = m_holder; m_holder = -1; m_gap = 1; m_pre = 1'b1;
            end else if (m_held < BURST) begin
                m_held++;
            end
        end else if (m_gap != 0) begin
            m_gap = 0;
        end else if (r != 0) begin
            m_holder = pick(r, p, m_last);
            m_held   = 1;
            m_id     = m_holder;
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [7:0] eg;
        eg = '0;
        if (m_holder >= 0) eg[m_holder] = 1'b1;
        check_eq({tag, "_grant"}, 32'(grant), 32'(eg));
        check_eq({tag, "_vld"}, 32'(grant_vld), 32'(m_holder >= 0));
        check_eq({tag, "_id"}, 32'(grant_id), 32'(m_id));
        check_eq({tag, "_pre"}, 32'(preempt), 32'(m_pre));
    endtask

    // Drive inputs, advance one edge, update model, compare 1 ns later.
    task automatic cycle(input string tag, input logic [7:0] r, input logic [7:0] p,
                         input logic [7:0] l);
        req  = r;
        prio = p;
        lock = l;
        @(posedge clk);
        model_step(r, p, l);
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        prio = '0;
        lock = '0;
        #1;
        model_reset();
        check_outputs("rst");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = '0; prio = '0; lock = '0;

        // All ports request; each holder drops one cycle after its grant.
        do_reset();
        n_seen = 0; gap_cnt = 0; prev_vld = 1'b0;
        for (int c = 0; c < 60 && n_seen < 9; c++) begin
            rr = 8'hFF;
            if (m_holder >= 0) rr[m_holder] = 1'b0;
            cycle("rr8", rr, 8'h00, 8'h00);
            if (grant_vld && !prev_vld) begin
                check_eq("rr8_order", 32'(grant_id), 32'(n_seen % PORT));
                if (n_seen > 0) check_eq("rr8_dead", 32'(gap_cnt), 32'd2);
                n_seen++;
                gap_cnt = 0;
            end else if (!grant_vld) begin
                gap_cnt++;
            end
            prev_vld = grant_vld;
        end
        check_eq("rr8_count", 32'(n_seen), 32'd9);

        // Two ports contending, burst limit forces rotation.
        do_reset();
        pre_cnt = 0; cnt_a = 0; cnt_b = 0;
        for (int c = 0; c < 20; c++) begin
            cycle("burst", 8'h81, 8'h00, 8'h00);
            if (preempt) pre_cnt++;
            if (grant == 8'h01) cnt_a++;
            if (grant == 8'h80) cnt_b++;
        end
        check_eq("burst_pre", 32'(pre_cnt), 32'd3);
        check_eq("burst_p0", 32'(cnt_a), 32'd8);
        check_eq("burst_p7", 32'(cnt_b), 32'd6);

        // Lock on port 0 exempts it; release lock -> rotation.
        do_reset();
        pre_cnt = 0; cnt_a = 0; cnt_b = 0;
        for (int c = 0; c < 30; c++) begin
            cycle("lock", 8'h81, 8'h00, 8'h01);
            if (preempt) pre_cnt++;
            if (grant == 8'h01) cnt_a++;
        end
        check_eq("lock_pre", 32'(pre_cnt), 32'd0);
        check_eq("lock_hold", 32'(cnt_a), 32'd30);
        for (int c = 0; c < 10; c++) begin
            cycle("unlock", 8'h81, 8'h00, 8'h00);
            if (grant == 8'h80) cnt_b = 1;
        end
        check_eq("unlock_rot", 32'(cnt_b), 32'd1);

        // last=2 then req=0x31: prio selects port 0, otherwise port 4.
        for (int v = 0; v < 2; v++) begin
            do_reset();
            cycle("last2", 8'h04, 8'h00, 8'h00);
            cycle("last2", 8'h00, 8'h00, 8'h00);
            cycle("last2", 8'h00, 8'h00, 8'h00);
            cycle("prio", 8'h31, (v == 0) ? 8'h01 : 8'h00, 8'h00);
            check_eq("prio_win", 32'(grant_id), (v == 0) ? 32'd0 : 32'd4);
        end

        // Sole requester is never preempted.
        do_reset();
        pre_cnt = 0; cnt_a = 0;
        for (int c = 0; c < 40; c++) begin
            cycle("sole", 8'h08, 8'h00, 8'h00);
            if (preempt) pre_cnt++;
            if (grant == 8'h08) cnt_a++;
        end
        check_eq("sole_pre", 32'(pre_cnt), 32'd0);
        check_eq("sole_hold", 32'(cnt_a), 32'd40);

        // Async reset mid-grant, then restart from port 0.
        do_reset();
        for (int c = 0; c < 3; c++) cycle("pre_rst", 8'h20, 8'h00, 8'h00);
        check_eq("p5_granted", 32'(grant), 32'h20);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_eq("async_rst_grant", 32'(grant), 32'd0);
        check_outputs("async_rst");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle("after_rst", 8'h21, 8'h00, 8'h00);
        check_eq("after_rst_id", 32'(grant_id), 32'd0);

        // Random traffic.
        do_reset();
        rr = '0; pp = '0; ll = '0;
        for (int c = 0; c < 500; c++) begin
            for (int b = 0; b < PORT; b++) begin
                if ($urandom_range(0, 5) == 0) rr[b] = ~rr[b];
                if ($urandom_range(0, 9) == 0) ll[b] = ~ll[b];
            end
            pp = 8'($urandom) & 8'($urandom);
            cycle("rand", rr, pp, ll);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
